// File: rtl/uart_tx_frame_if.sv
// Host-side handshake bundle for uart_tx_frame.
//   tx_data  : word to transmit (DATA_BITS wide)
//   tx_valid : tx_data is valid
//   tx_ready : transmitter can accept a word
// master = data source, slave = transmitter.
interface uart_tx_frame_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// even/odd parity bit, STOP_BITS stop bits. One word is accepted per valid/ready
// handshake (only while idle) and serialised onto a registered TXD line.
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-low reset
//   tx      : slave side of uart_tx_frame_if (tx_data, tx_valid, tx_ready)
//   txd     : serial line, idles high, registered
//   busy    : high while a frame is in progress
//   tx_done : one-cycle pulse in the last clk of the last stop bit
module uart_tx_frame #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_frame_if.slave        tx,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned BW  = $clog2(CLKS_PER_BIT);
    // Bit counter indexes both data bits and stop bits; DATA_BITS is always the larger.
    localparam int unsigned BCW = $clog2(DATA_BITS + 1);

    localparam logic [BW-1:0]  BaudMax  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] DataLast = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] StopLast = BCW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [BCW-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 txd_q, txd_d;
    logic                 bit_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        txd_d    = txd_q;
        tx_done  = 1'b0;
        bit_end  = (baud_q == BaudMax);

        // Baud counter free-runs across each bit and clears on every bit boundary.
        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
                txd_d  = 1'b1;
                if (tx.tx_valid) begin
                    state_d  = StStart;
                    shift_d  = tx.tx_data;
                    // Parity is frozen with the captured word, not the live input.
                    parity_d = (^tx.tx_data) ^ (PARITY_ODD != 0);
                    txd_d    = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DataLast) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = StParity;
                            txd_d   = parity_q;
                        end else begin
                            state_d = StStop;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        txd_d = shift_d[0];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    bit_d   = '0;
                    txd_d   = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_q == StopLast) begin
                        tx_done = 1'b1;
                        state_d = StIdle;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign tx.tx_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign txd         = txd_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_8n1;
    logic rst_7;
    int   total = 0;
    int   bad   = 0;

    logic txd_8n1, busy_8n1, done_8n1;
    logic txd_7e2, busy_7e2, done_7e2;
    logic txd_7o2, busy_7o2, done_7o2;

    uart_tx_frame_if #(.DATA_BITS(8)) if_8n1 ();
    uart_tx_frame_if #(.DATA_BITS(7)) if_7e2 ();
    uart_tx_frame_if #(.DATA_BITS(7)) if_7o2 ();

    uart_tx_frame #(
        .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .CLKS_PER_BIT(4)
    ) u_8n1 (
        .clk(clk), .reset(rst_8n1), .tx(if_8n1), .txd(txd_8n1), .busy(busy_8n1),
        .tx_done(done_8n1)
    );

    uart_tx_frame #(
        .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .CLKS_PER_BIT(3)
    ) u_7e2 (
        .clk(clk), .reset(rst_7), .tx(if_7e2), .txd(txd_7e2), .busy(busy_7e2),
        .tx_done(done_7e2)
    );

    uart_tx_frame #(
        .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .CLKS_PER_BIT(3)
    ) u_7o2 (
        .clk(clk), .reset(rst_7), .tx(if_7o2), .txd(txd_7o2), .busy(busy_7o2),
        .tx_done(done_7o2)
    );

    // {txd, busy, tx_ready, tx_done} while idle/reset is 4'b1010.
    task automatic test_reset();
        rst_8n1 = 1'b0;
        rst_7   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1} !== 4'b1010) begin
                bad++;
                $display("FAIL reset_hold_8n1 cyc %0d: got %b expected 1010", i,
                         {txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1});
            end
            total++;
            if ({txd_7e2, busy_7e2, if_7e2.tx_ready, done_7e2,
                 txd_7o2, busy_7o2, if_7o2.tx_ready, done_7o2} !== 8'b1010_1010) begin
                bad++;
                $display("FAIL reset_hold_7x2 cyc %0d: got %b expected 10101010", i,
                         {txd_7e2, busy_7e2, if_7e2.tx_ready, done_7e2,
                          txd_7o2, busy_7o2, if_7o2.tx_ready, done_7o2});
            end
        end
        rst_8n1 = 1'b1;
        rst_7   = 1'b1;
        @(negedge clk);
        total++;
        if ({txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_release_8n1: got %b expected 1010",
                     {txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1});
        end
    endtask

    // 0xA5 8N1: 0, 1,0,1,0,0,1,0,1, 1 (bit index = position in frame).
    task automatic test_8n1();
        logic [9:0] exp;
        exp = 10'b11_0100_1010;
        @(negedge clk);
        total++;
        if (if_8n1.tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL 8n1_ready_before: got %b expected 1", if_8n1.tx_ready);
        end
        if_8n1.tx_data  = 8'hA5;
        if_8n1.tx_valid = 1'b1;
        @(negedge clk);
        if_8n1.tx_valid = 1'b0;
        if_8n1.tx_data  = 8'h00;
        for (int c = 1; c <= 40; c++) begin
            total++;
            if ({txd_8n1, busy_8n1, done_8n1} !== {exp[(c-1)/4], 1'b1, (c == 40)}) begin
                bad++;
                $display("FAIL 8n1_frame clk %0d: got txd/busy/done %b expected %b", c,
                         {txd_8n1, busy_8n1, done_8n1}, {exp[(c-1)/4], 1'b1, (c == 40)});
            end
            @(negedge clk);
        end
        total++;
        if ({txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1} !== 4'b1010) begin
            bad++;
            $display("FAIL 8n1_idle_after clk 41: got %b expected 1010",
                     {txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1});
        end
    endtask

    // Even and odd 7x2 instances fed the same word; expected frames hand-computed.
    task automatic test_parity(input logic [6:0] data, input logic [10:0] exp_e,
                               input logic [10:0] exp_o);
        @(negedge clk);
        if_7e2.tx_data  = data;
        if_7o2.tx_data  = data;
        if_7e2.tx_valid = 1'b1;
        if_7o2.tx_valid = 1'b1;
        @(negedge clk);
        if_7e2.tx_valid = 1'b0;
        if_7o2.tx_valid = 1'b0;
        if_7e2.tx_data  = ~data;
        if_7o2.tx_data  = ~data;
        for (int c = 1; c <= 33; c++) begin
            total++;
            if ({txd_7e2, busy_7e2, done_7e2} !== {exp_e[(c-1)/3], 1'b1, (c == 33)}) begin
                bad++;
                $display("FAIL 7e2_frame data %h clk %0d: got %b expected %b", data, c,
                         {txd_7e2, busy_7e2, done_7e2}, {exp_e[(c-1)/3], 1'b1, (c == 33)});
            end
            total++;
            if ({txd_7o2, busy_7o2, done_7o2} !== {exp_o[(c-1)/3], 1'b1, (c == 33)}) begin
                bad++;
                $display("FAIL 7o2_frame data %h clk %0d: got %b expected %b", data, c,
                         {txd_7o2, busy_7o2, done_7o2}, {exp_o[(c-1)/3], 1'b1, (c == 33)});
            end
            @(negedge clk);
        end
        total++;
        if ({txd_7e2, busy_7e2, if_7e2.tx_ready, txd_7o2, busy_7o2, if_7o2.tx_ready}
            !== 6'b101_101) begin
            bad++;
            $display("FAIL 7x2_idle_after data %h: got %b expected 101101", data,
                     {txd_7e2, busy_7e2, if_7e2.tx_ready, txd_7o2, busy_7o2, if_7o2.tx_ready});
        end
    endtask

    // tx_valid held: 0x0F frame, one idle clk, then 0xF0 frame.
    task automatic test_back_to_back();
        logic [9:0] exp_a;
        logic [9:0] exp_b;
        exp_a = 10'b10_0001_1110;
        exp_b = 10'b11_1110_0000;
        @(negedge clk);
        if_8n1.tx_data  = 8'h0F;
        if_8n1.tx_valid = 1'b1;
        @(negedge clk);
        if_8n1.tx_data  = 8'hF0;
        for (int c = 1; c <= 40; c++) begin
            total++;
            if ({txd_8n1, busy_8n1, done_8n1} !== {exp_a[(c-1)/4], 1'b1, (c == 40)}) begin
                bad++;
                $display("FAIL b2b_first clk %0d: got %b expected %b", c,
                         {txd_8n1, busy_8n1, done_8n1}, {exp_a[(c-1)/4], 1'b1, (c == 40)});
            end
            @(negedge clk);
        end
        total++;
        if ({txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1} !== 4'b1010) begin
            bad++;
            $display("FAIL b2b_gap_idle: got %b expected 1010",
                     {txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1});
        end
        @(negedge clk);
        if_8n1.tx_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            total++;
            if ({txd_8n1, busy_8n1, done_8n1} !== {exp_b[(c-1)/4], 1'b1, (c == 40)}) begin
                bad++;
                $display("FAIL b2b_second clk %0d: got %b expected %b", c,
                         {txd_8n1, busy_8n1, done_8n1}, {exp_b[(c-1)/4], 1'b1, (c == 40)});
            end
            @(negedge clk);
        end
        total++;
        if ({txd_8n1, busy_8n1, if_8n1.tx_ready} !== 3'b101) begin
            bad++;
            $display("FAIL b2b_idle_after: got %b expected 101",
                     {txd_8n1, busy_8n1, if_8n1.tx_ready});
        end
    endtask

    // Reset during data bit 3 of 0xA5 (a 0 bit), then a clean 0x3C frame.
    task automatic test_reset_mid_frame();
        logic [9:0] exp;
        exp = 10'b10_0111_1000;
        @(negedge clk);
        if_8n1.tx_data  = 8'hA5;
        if_8n1.tx_valid = 1'b1;
        @(negedge clk);
        if_8n1.tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        total++;
        if ({txd_8n1, busy_8n1} !== 2'b01) begin
            bad++;
            $display("FAIL mid_pre_reset: got txd/busy %b expected 01", {txd_8n1, busy_8n1});
        end
        rst_8n1 = 1'b0;
        #1;
        total++;
        if ({txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1} !== 4'b1010) begin
            bad++;
            $display("FAIL mid_async_reset: got %b expected 1010",
                     {txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({txd_8n1, done_8n1} !== 2'b10) begin
                bad++;
                $display("FAIL mid_reset_hold %0d: got txd/done %b expected 10", i,
                         {txd_8n1, done_8n1});
            end
        end
        rst_8n1 = 1'b1;
        @(negedge clk);
        total++;
        if ({txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1} !== 4'b1010) begin
            bad++;
            $display("FAIL mid_after_release: got %b expected 1010",
                     {txd_8n1, busy_8n1, if_8n1.tx_ready, done_8n1});
        end
        if_8n1.tx_data  = 8'h3C;
        if_8n1.tx_valid = 1'b1;
        @(negedge clk);
        if_8n1.tx_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            total++;
            if ({txd_8n1, busy_8n1, done_8n1} !== {exp[(c-1)/4], 1'b1, (c == 40)}) begin
                bad++;
                $display("FAIL mid_fresh_frame clk %0d: got %b expected %b", c,
                         {txd_8n1, busy_8n1, done_8n1}, {exp[(c-1)/4], 1'b1, (c == 40)});
            end
            @(negedge clk);
        end
        total++;
        if ({txd_8n1, busy_8n1, if_8n1.tx_ready} !== 3'b101) begin
            bad++;
            $display("FAIL mid_fresh_idle: got %b expected 101",
                     {txd_8n1, busy_8n1, if_8n1.tx_ready});
        end
    endtask

    initial begin
        if_8n1.tx_data  = '0;
        if_8n1.tx_valid = 1'b0;
        if_7e2.tx_data  = '0;
        if_7e2.tx_valid = 1'b0;
        if_7o2.tx_data  = '0;
        if_7o2.tx_valid = 1'b0;
        test_reset();
        test_8n1();
        test_parity(7'h55, 11'b110_1010_1010, 11'b111_1010_1010);
        test_parity(7'h00, 11'b110_0000_0000, 11'b111_0000_0000);
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
